// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS bit positions, FSM states and divider limits shared by the UART
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_TX_BUSY      = 0;
    localparam int ST_RX_VALID     = 1;
    localparam int ST_RX_OVERRUN   = 2;
    localparam int ST_RX_FRAME_ERR = 3;

    localparam logic [15:0] MIN_DIV = 16'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_e;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/wb_uart_rx.sv
// wb_uart_rx: synchronised 8N1 receiver emitting the assembled byte with store and frame-error strobes
module wb_uart_rx
    import uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_i,
    input  logic [15:0] div_i,
    output logic [7:0]  byte_o,
    output logic        store_o,
    output logic        frame_err_o
);

    logic        sync1_q, sync2_q, prev_q;
    uart_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        bit_end, half_end;

    assign bit_end  = cnt_q == div_q - 16'd1;
    assign half_end = cnt_q == (div_q >> 1) - 16'd1;
    assign byte_o   = sh_q;

    // two-flop synchroniser plus one extra stage to spot the falling start edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // receiver state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    // start detection, mid-start recheck, data sampling and stop-bit verdict
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        store_o     = 1'b0;
        frame_err_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    div_d   = div_i;
                end
            end
            S_START: begin
                if (half_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    sh_d  = {sync2_q, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    store_o     = sync2_q;
                    frame_err_o = !sync2_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: rtl/wb_uart_lite.sv
// wb_uart_lite: Wishbone-attached 8N1 UART with DATA, STATUS and DIV registers and an rx_valid interrupt
module wb_uart_lite
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUDRATE = 115200
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_wdata_i,
    output logic [31:0] wb_rdata_o,
    input  logic        wb_wr_en_i,
    input  logic [3:0]  wb_byte_en_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        uart_tx_o,
    input  logic        uart_rx_i,
    output logic        irq_o
);

    localparam logic [15:0] DEFAULT_DIV = 16'(CLK_FREQ / BAUDRATE);

    logic        ack_q;
    logic [15:0] div_q, div_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_ovr_q, rx_ovr_d;
    logic        rx_ferr_q, rx_ferr_d;

    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_q, tx_d;

    logic [1:0]  reg_sel;
    logic        access, acc_wr, acc_rd;
    logic        tx_start, rx_read, status_wr, div_wr;
    logic        tx_busy, tx_bit_end;
    logic [3:0]  status;
    logic [15:0] div_wdata;
    logic [7:0]  rx_byte;
    logic        rx_store, rx_ferr;
    logic        unused_bits;

    assign unused_bits = ^{wb_addr_i[31:4], wb_addr_i[1:0], wb_wdata_i[31:16], wb_byte_en_i[3:2]};

    // the ack cycle is the single point where a bus access takes effect
    assign reg_sel   = wb_addr_i[3:2];
    assign access    = ack_q && wb_cyc_i && wb_stb_i;
    assign acc_wr    = access && wb_wr_en_i;
    assign acc_rd    = access && !wb_wr_en_i;
    assign tx_busy   = tx_state_q != S_IDLE;
    assign tx_start  = acc_wr && reg_sel == REG_DATA && wb_byte_en_i[0] && !tx_busy;
    assign rx_read   = acc_rd && reg_sel == REG_DATA;
    assign status_wr = acc_wr && reg_sel == REG_STATUS && wb_byte_en_i[0];
    assign div_wr    = acc_wr && reg_sel == REG_DIV && |wb_byte_en_i[1:0];
    assign div_wdata = {wb_byte_en_i[1] ? wb_wdata_i[15:8] : div_q[15:8],
                        wb_byte_en_i[0] ? wb_wdata_i[7:0]  : div_q[7:0]};
    assign tx_bit_end = tx_cnt_q == tx_div_q - 16'd1;

    assign wb_ack_o  = ack_q;
    assign uart_tx_o = tx_q;
    assign irq_o     = rx_valid_q;

    wb_uart_rx u_rx (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_i        (uart_rx_i),
        .div_i       (div_q),
        .byte_o      (rx_byte),
        .store_o     (rx_store),
        .frame_err_o (rx_ferr)
    );

    // assemble STATUS and drive read data only while acknowledging
    always_comb begin
        status                  = '0;
        status[ST_TX_BUSY]      = tx_busy;
        status[ST_RX_VALID]     = rx_valid_q;
        status[ST_RX_OVERRUN]   = rx_ovr_q;
        status[ST_RX_FRAME_ERR] = rx_ferr_q;
        wb_rdata_o = !ack_q                ? 32'd0 :
                     reg_sel == REG_DATA   ? {24'd0, rx_byte_q} :
                     reg_sel == REG_STATUS ? {28'd0, status} :
                     reg_sel == REG_DIV    ? {16'd0, div_q} : 32'd0;
    end

    // register file next state; a byte store beats a simultaneous DATA read and set beats clear
    always_comb begin
        div_d      = div_wr ? clamp_div(div_wdata) : div_q;
        rx_byte_d  = rx_store ? rx_byte : rx_byte_q;
        rx_valid_d = rx_store ? 1'b1 : rx_read ? 1'b0 : rx_valid_q;
        rx_ovr_d   = (rx_store && rx_valid_q && !rx_read) ||
                     (rx_ovr_q && !(status_wr && wb_wdata_i[ST_RX_OVERRUN]));
        rx_ferr_d  = rx_ferr || (rx_ferr_q && !(status_wr && wb_wdata_i[ST_RX_FRAME_ERR]));
    end

    // bus acknowledge and register file state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q      <= 1'b0;
            div_q      <= DEFAULT_DIV;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            ack_q      <= wb_cyc_i && wb_stb_i && !ack_q;
            div_q      <= div_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // transmitter next state: start, eight data bits LSB first, stop, each lasting the latched divider
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = tx_q;
        case (tx_state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    tx_state_d = S_START;
                    tx_cnt_d   = '0;
                    tx_div_d   = div_q;
                    tx_sh_d    = wb_wdata_i[7:0];
                    tx_d       = 1'b0;
                end
            end
            S_START: begin
                if (tx_bit_end) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_sh_q[0];
                    tx_sh_d    = tx_sh_q >> 1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_d    = tx_sh_q[0];
                        tx_sh_d = tx_sh_q >> 1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (tx_bit_end) begin
                    tx_state_d = S_IDLE;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // transmitter state register; reset forces the line idle-high at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_wb_uart_lite.sv
// tb_wb_uart_lite: scoreboard-driven bench for the Wishbone UART
module tb_wb_uart_lite;

    localparam int DIV0 = 217;
    localparam logic [31:0] A_DATA   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_DIV    = 32'h8;
    localparam logic [31:0] A_RSVD   = 32'hC;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [31:0] wb_addr_i = '0;
    logic [31:0] wb_wdata_i = '0;
    logic [31:0] wb_rdata_o;
    logic        wb_wr_en_i = 1'b0;
    logic [3:0]  wb_byte_en_i = '0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic        uart_tx_o;
    logic        uart_rx_i = 1'b1;
    logic        irq_o;

    int          total = 0;
    int          bad = 0;
    longint      cycles = 0;
    int          last_lat = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic        m_valid = 1'b0;
    logic        m_ovr = 1'b0;
    logic        m_ferr = 1'b0;

    wb_uart_lite dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .wb_addr_i    (wb_addr_i),
        .wb_wdata_i   (wb_wdata_i),
        .wb_rdata_o   (wb_rdata_o),
        .wb_wr_en_i   (wb_wr_en_i),
        .wb_byte_en_i (wb_byte_en_i),
        .wb_stb_i     (wb_stb_i),
        .wb_cyc_i     (wb_cyc_i),
        .wb_ack_o     (wb_ack_o),
        .uart_tx_o    (uart_tx_o),
        .uart_rx_i    (uart_rx_i),
        .irq_o        (irq_o)
    );

    always #20 clk_i = ~clk_i;

    always @(posedge clk_i) cycles <= cycles + 1;

    initial begin
        #4_000_000;
        $display("FAIL watchdog expired at cycle %0d", cycles);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_status(input logic busy);
        return {28'd0, m_ferr, m_ovr, m_valid, busy};
    endfunction

    task automatic wait_cycle(input longint t);
        while (cycles < t) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        n = 0;
        wb_addr_i = a;
        wb_wdata_i = d;
        wb_byte_en_i = be;
        wb_wr_en_i = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        do begin
            @(posedge clk_i);
            #1;
            n++;
        end while (!wb_ack_o && n < 20);
        last_lat = n;
        total++;
        if (wb_ack_o !== 1'b1) begin
            bad++;
            $display("FAIL wb_write_ack addr=%h got=%b want=1", a, wb_ack_o);
        end
        @(posedge clk_i);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_wr_en_i = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        n = 0;
        wb_addr_i = a;
        wb_byte_en_i = 4'hF;
        wb_wr_en_i = 1'b0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        do begin
            @(posedge clk_i);
            #1;
            n++;
        end while (!wb_ack_o && n < 20);
        last_lat = n;
        d = wb_rdata_o;
        total++;
        if (wb_ack_o !== 1'b1) begin
            bad++;
            $display("FAIL wb_read_ack addr=%h got=%b want=1", a, wb_ack_o);
        end
        @(posedge clk_i);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
    endtask

    // drive one serial frame; the model records what the receiver must report
    task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
        logic [9:0] frame;
        if (stop) begin
            if (m_valid) begin
                m_ovr = 1'b1;
                void'(rx_q.pop_front());
            end
            rx_q.push_back(b);
            m_valid = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        frame = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rx_i = frame[k];
            repeat (d) begin
                @(posedge clk_i);
                #1;
            end
        end
        uart_rx_i = 1'b1;
        repeat (4) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // sample every bit of a frame at its centre against the byte at the head of the TX scoreboard
    task automatic check_tx_frame(input longint c0, input int d);
        logic [7:0] b;
        logic       e;
        if (tx_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_scoreboard empty got=0 entries want>=1");
            return;
        end
        b = tx_q.pop_front();
        for (int k = 0; k < 10; k++) begin
            wait_cycle(c0 + longint'(k * d + d / 2));
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            total++;
            if (uart_tx_o !== e) begin
                bad++;
                $display("FAIL tx_bit%0d byte=%h div=%0d got=%b want=%b", k, b, d, uart_tx_o, e);
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        #2 rst_ni = 1'b0;
        #3;
        total++;
        if ({wb_ack_o, wb_rdata_o, uart_tx_o, irq_o} !== {1'b0, 32'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got ack=%b rdata=%h tx=%b irq=%b want 0/0/1/0",
                     wb_ack_o, wb_rdata_o, uart_tx_o, irq_o);
        end
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        wb_read(A_DIV, d);
        total++;
        if (d !== 32'd217) begin
            bad++;
            $display("FAIL reset_div got=%h want=%h", d, 32'd217);
        end
        wb_read(A_STATUS, d);
        total++;
        if (d !== exp_status(1'b0)) begin
            bad++;
            $display("FAIL reset_status got=%h want=%h", d, exp_status(1'b0));
        end
        wb_write(A_RSVD, 32'hFFFF_FFFF, 4'hF);
        wb_read(A_RSVD, d);
        total++;
        if (d !== 32'd0) begin
            bad++;
            $display("FAIL rsvd_read got=%h want=0", d);
        end
        wb_read(A_DIV, d);
        total++;
        if (d !== 32'd217) begin
            bad++;
            $display("FAIL rsvd_write_div got=%h want=%h", d, 32'd217);
        end
    endtask

    task automatic test_tx;
        logic [31:0] d;
        longint      c0;
        total++;
        if (uart_tx_o !== 1'b1) begin
            bad++;
            $display("FAIL tx_idle got=%b want=1", uart_tx_o);
        end
        tx_q.push_back(8'hA5);
        wb_write(A_DATA, 32'h0000_00A5, 4'h1);
        c0 = cycles;
        total++;
        if (last_lat != 1) begin
            bad++;
            $display("FAIL tx_ack_latency got=%0d want=1", last_lat);
        end
        total++;
        if (uart_tx_o !== 1'b0) begin
            bad++;
            $display("FAIL tx_start_edge got=%b want=0", uart_tx_o);
        end
        fork
            check_tx_frame(c0, DIV0);
            begin
                wait_cycle(c0 + 500);
                wb_write(A_DATA, 32'h0000_0000, 4'h1);
            end
        join
        wait_cycle(c0 + 10 * DIV0 - 2);
        wb_read(A_STATUS, d);
        total++;
        if (d !== exp_status(1'b1)) begin
            bad++;
            $display("FAIL tx_busy_last_cycle got=%h want=%h", d, exp_status(1'b1));
        end
        wb_read(A_STATUS, d);
        total++;
        if (d !== exp_status(1'b0)) begin
            bad++;
            $display("FAIL tx_busy_cleared got=%h want=%h", d, exp_status(1'b0));
        end
        total++;
        if (uart_tx_o !== 1'b1) begin
            bad++;
            $display("FAIL tx_after_frame got=%b want=1", uart_tx_o);
        end
    endtask

    task automatic test_rx;
        logic [31:0] d;
        logic [31:0] e;
        send_rx(8'h3C, 1'b1, DIV0);
        wb_read(A_STATUS, d);
        total++;
        if (d !== exp_status(1'b0)) begin
            bad++;
            $display("FAIL rx_status got=%h want=%h", d, exp_status(1'b0));
        end
        total++;
        if (irq_o !== m_valid) begin
            bad++;
            $display("FAIL rx_irq got=%b want=%b", irq_o, m_valid);
        end
        wb_read(A_DATA, d);
        e = {24'd0, rx_q.pop_front()};
        m_valid = 1'b0;
        total++;
        if (d !== e) begin
            bad++;
            $display("FAIL rx_data got=%h want=%h", d, e);
        end
        wb_read(A_STATUS, d);
        total++;
        if (d !== exp_status(1'b0)) begin
            bad++;
            $display("FAIL rx_status_after_read got=%h want=%h", d, exp_status(1'b0));
        end
        total++;
        if (irq_o !== m_valid) begin
            bad++;
            $display("FAIL rx_irq_after_read got=%b want=%b", irq_o, m_valid);
        end
    endtask

    task automatic test_overrun;
        logic [31:0] d;
        logic [31:0] e;
        send_rx(8'h11, 1'b1, DIV0);
        send_rx(8'h22, 1'b1, DIV0);
        wb_read(A_STATUS, d);
        total++;
        if (d !== exp_status(1'b0)) begin
            bad++;
            $display("FAIL ovr_status got=%h want=%h", d, exp_status(1'b0));
        end
        wb_read(A_DATA, d);
        e = {24'd0, rx_q.pop_front()};
        m_valid = 1'b0;
        total++;
        if (d !== e) begin
            bad++;
            $display("FAIL ovr_data got=%h want=%h", d, e);
        end
        wb_write(A_STATUS, 32'h4, 4'h1);
        m_ovr = 1'b0;
        wb_read(A_STATUS, d);
        total++;
        if (d !== exp_status(1'b0)) begin
            bad++;
            $display("FAIL ovr_clear got=%h want=%h", d, exp_status(1'b0));
        end
    endtask

    task automatic test_frame_err;
        logic [31:0] d;
        logic [31:0] e;
        send_rx(8'h55, 1'b0, DIV0);
        wb_read(A_STATUS, d);
        total++;
        if (d !== exp_status(1'b0)) begin
            bad++;
            $display("FAIL ferr_status got=%h want=%h", d, exp_status(1'b0));
        end
        total++;
        if (irq_o !== m_valid) begin
            bad++;
            $display("FAIL ferr_irq got=%b want=%b", irq_o, m_valid);
        end
        wb_write(A_STATUS, 32'h8, 4'h1);
        m_ferr = 1'b0;
        uart_rx_i = 1'b0;
        repeat (50) @(posedge clk_i);
        #1 uart_rx_i = 1'b1;
        repeat (300) @(posedge clk_i);
        #1;
        wb_read(A_STATUS, d);
        total++;
        if (d !== exp_status(1'b0)) begin
            bad++;
            $display("FAIL glitch_status got=%h want=%h", d, exp_status(1'b0));
        end
        send_rx(8'h5A, 1'b1, DIV0);
        wb_read(A_DATA, d);
        e = {24'd0, rx_q.pop_front()};
        m_valid = 1'b0;
        total++;
        if (d !== e) begin
            bad++;
            $display("FAIL post_glitch_data got=%h want=%h", d, e);
        end
    endtask

    task automatic test_div;
        logic [31:0] d;
        longint      c0;
        wb_write(A_DIV, 32'd2, 4'hF);
        wb_read(A_DIV, d);
        total++;
        if (d !== 32'd4) begin
            bad++;
            $display("FAIL div_clamp got=%h want=%h", d, 32'd4);
        end
        wb_write(A_DIV, DIV0, 4'hF);
        tx_q.push_back(8'h3C);
        wb_write(A_DATA, 32'h0000_003C, 4'h1);
        c0 = cycles;
        fork
            check_tx_frame(c0, DIV0);
            begin
                wait_cycle(c0 + 300);
                wb_write(A_DIV, 32'd100, 4'h3);
            end
        join
        wait_cycle(c0 + 10 * DIV0 + 5);
        tx_q.push_back(8'h96);
        wb_write(A_DATA, 32'h0000_0096, 4'h1);
        c0 = cycles;
        check_tx_frame(c0, 100);
        wb_read(A_DIV, d);
        total++;
        if (d !== 32'd100) begin
            bad++;
            $display("FAIL div_readback got=%h want=%h", d, 32'd100);
        end
        wait_cycle(c0 + 1005);
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] d;
        longint      c0;
        send_rx(8'h81, 1'b1, 100);
        wb_write(A_DATA, 32'h0000_0000, 4'h1);
        c0 = cycles;
        wait_cycle(c0 + 150);
        total++;
        if (uart_tx_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_frame_low got=%b want=0", uart_tx_o);
        end
        #5 rst_ni = 1'b0;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        rx_q.delete();
        tx_q.delete();
        #1;
        total++;
        if ({uart_tx_o, irq_o, wb_ack_o, wb_rdata_o} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL mid_reset_outputs got tx=%b irq=%b ack=%b rdata=%h want 1/0/0/0",
                     uart_tx_o, irq_o, wb_ack_o, wb_rdata_o);
        end
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        wb_read(A_STATUS, d);
        total++;
        if (d !== exp_status(1'b0)) begin
            bad++;
            $display("FAIL mid_reset_status got=%h want=%h", d, exp_status(1'b0));
        end
        wb_read(A_DIV, d);
        total++;
        if (d !== 32'd217) begin
            bad++;
            $display("FAIL mid_reset_div got=%h want=%h", d, 32'd217);
        end
        repeat (300) @(posedge clk_i);
        #1;
        total++;
        if (uart_tx_o !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_tx_idle got=%b want=1", uart_tx_o);
        end
    endtask

    initial begin
        test_reset;
        test_tx;
        test_rx;
        test_overrun;
        test_frame_err;
        test_div;
        test_reset_mid_frame;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
